// File: rtl/conv11_in_seq_if.sv
// Handshake bundle for the 1x1-conv input sequencer: frame control, the upstream
// valid/ready pair and the downstream beat with its channel/pixel tags.
interface conv11_in_seq_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CH_NUM  = 16,
  parameter int unsigned PIX_NUM = 196
);
  localparam int unsigned CH_W  = $clog2(CH_NUM);
  localparam int unsigned PIX_W = $clog2(PIX_NUM);

  logic              start;
  logic              abort;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_out;
  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] data_out;
  logic [CH_W-1:0]   ch_idx;
  logic [PIX_W-1:0]  pix_idx;
  logic              last_ch;
  logic              last;
  logic              busy;
  logic              done;

  // Sequencer side.
  modport slave (
    input  start, abort, valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out, ch_idx, pix_idx, last_ch, last, busy, done
  );

  // Environment side: upstream source, downstream sink and frame controller.
  modport master (
    output start, abort, valid_in, data_in, ready_in,
    input  ready_out, valid_out, data_out, ch_idx, pix_idx, last_ch, last, busy, done
  );
endinterface

// File: rtl/conv11_in_seq.sv
// Input sequencer for a 1x1 convolution: accepts CH_NUM*PIX_NUM beats per frame and
// re-emits each one registered, tagged with its channel and pixel index.
module conv11_in_seq #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CH_NUM  = 16,
  parameter int unsigned PIX_NUM = 196
) (
  input logic             clk,
  input logic             rst_n,
  conv11_in_seq_if.slave  bus
);
  localparam int unsigned CH_W  = $clog2(CH_NUM);
  localparam int unsigned PIX_W = $clog2(PIX_NUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q,   state_d;
  logic [CH_W-1:0]   ch_cnt_q,  ch_cnt_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [CH_W-1:0]   ch_idx_q,  ch_idx_d;
  logic [PIX_W-1:0]  pix_idx_q, pix_idx_d;
  logic              last_ch_q, last_ch_d;
  logic              last_q,    last_d;

  logic ready_c;
  logic accept_c;
  logic consume_c;
  logic ch_end_c;
  logic pix_end_c;

  // Output slot may be refilled in the same cycle it is drained.
  assign ready_c   = (state_q == RUN) && (!valid_q || bus.ready_in);
  assign accept_c  = bus.valid_in && ready_c;
  assign consume_c = valid_q && bus.ready_in;
  assign ch_end_c  = (ch_cnt_q  == CH_W'(CH_NUM - 1));
  assign pix_end_c = (pix_cnt_q == PIX_W'(PIX_NUM - 1));

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    valid_d   = valid_q;
    data_d    = data_q;
    ch_idx_d  = ch_idx_q;
    pix_idx_d = pix_idx_q;
    last_ch_d = last_ch_q;
    last_d    = last_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          ch_cnt_d  = '0;
          pix_cnt_d = '0;
        end
      end
      RUN: begin
        if (accept_c && ch_end_c && pix_end_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (consume_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (consume_c) begin
      valid_d = 1'b0;
    end

    if (accept_c) begin
      valid_d   = 1'b1;
      data_d    = bus.data_in;
      ch_idx_d  = ch_cnt_q;
      pix_idx_d = pix_cnt_q;
      last_ch_d = ch_end_c;
      last_d    = ch_end_c && pix_end_c;
      if (ch_end_c) begin
        ch_cnt_d  = '0;
        pix_cnt_d = pix_end_c ? '0 : pix_cnt_q + PIX_W'(1);
      end else begin
        ch_cnt_d  = ch_cnt_q + CH_W'(1);
      end
    end

    // Abort wins over start, accept and the DRAIN->DONE step.
    if (bus.abort) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      ch_cnt_d  = '0;
      pix_cnt_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ch_idx_q  <= '0;
      pix_idx_q <= '0;
      last_ch_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ch_idx_q  <= ch_idx_d;
      pix_idx_q <= pix_idx_d;
      last_ch_q <= last_ch_d;
      last_q    <= last_d;
    end
  end

  assign bus.ready_out = ready_c;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.ch_idx    = ch_idx_q;
  assign bus.pix_idx   = pix_idx_q;
  assign bus.last_ch   = last_ch_q;
  assign bus.last      = last_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_conv11_in_seq.sv
// Bench for conv11_in_seq: directed beat table, multi-cycle corner sequences and a
// randomized run, all checked against a frame-level reference model.
module tb_conv11_in_seq;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CH_NUM  = 4;
  localparam int unsigned PIX_NUM = 3;
  localparam int unsigned N_BEATS = CH_NUM * PIX_NUM;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv11_in_seq_if #(.DATA_W(DATA_W), .CH_NUM(CH_NUM), .PIX_NUM(PIX_NUM)) bus ();

  conv11_in_seq #(.DATA_W(DATA_W), .CH_NUM(CH_NUM), .PIX_NUM(PIX_NUM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: frame in progress, beats accepted so far, the single output slot.
  bit          m_in_frame = 1'b0;
  bit          m_done_now = 1'b0;
  bit          m_out_full = 1'b0;
  int          m_acc      = 0;
  int          m_out_k    = 0;
  logic [7:0]  m_out_data = 8'h00;

  bit last_acc  = 1'b0;
  int acc_count = 0;
  int frames    = 0;

  typedef struct {
    logic [7:0] din;
    int         stall;
    logic [1:0] ch;
    logic [1:0] pix;
    logic       lch;
    logic       lst;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_done_now = 1'b0;
    m_out_full = 1'b0;
    m_acc      = 0;
    m_out_k    = 0;
    m_out_data = 8'h00;
  endtask

  function automatic bit model_ready();
    return m_in_frame && (m_acc < int'(N_BEATS)) && (!m_out_full || bus.ready_in);
  endfunction

  task automatic model_check();
    chk("ready_out", 32'(bus.ready_out), 32'(model_ready()));
    chk("valid_out", 32'(bus.valid_out), 32'(m_out_full));
    chk("busy",      32'(bus.busy),      32'(m_in_frame || m_done_now));
    chk("done",      32'(bus.done),      32'(m_done_now));
    if (m_out_full) begin
      chk("data_out", 32'(bus.data_out), 32'(m_out_data));
      chk("ch_idx",   32'(bus.ch_idx),   32'(m_out_k % int'(CH_NUM)));
      chk("pix_idx",  32'(bus.pix_idx),  32'(m_out_k / int'(CH_NUM)));
      chk("last_ch",  32'(bus.last_ch),  32'((m_out_k % int'(CH_NUM)) == int'(CH_NUM) - 1));
      chk("last",     32'(bus.last),     32'(m_out_k == int'(N_BEATS) - 1));
    end
  endtask

  task automatic model_step();
    bit acc, cons, fin, idle;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (bus.abort) begin
      m_in_frame = 1'b0;
      m_done_now = 1'b0;
      m_out_full = 1'b0;
      m_acc      = 0;
      return;
    end
    acc  = model_ready() && bus.valid_in;
    cons = m_out_full && bus.ready_in;
    fin  = m_in_frame && (m_acc == int'(N_BEATS)) && cons;
    idle = !m_in_frame && !m_done_now;
    if (acc) begin
      m_out_data = bus.data_in;
      m_out_k    = m_acc;
      m_acc++;
      m_out_full = 1'b1;
    end else if (cons) begin
      m_out_full = 1'b0;
    end
    if (fin) m_in_frame = 1'b0;
    m_done_now = fin;
    if (idle && bus.start) begin
      m_in_frame = 1'b1;
      m_acc      = 0;
    end
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rise.
  task automatic cycle();
    @(negedge clk);
    model_check();
    last_acc = bus.valid_in && bus.ready_out;
    if (last_acc) acc_count++;
    if (bus.done) frames++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    int w = 0;
    cycle();
    while (!last_acc && w < 20) begin
      cycle();
      w++;
    end
    chk("accept_seen", 32'(last_acc), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_ready_out"}, 32'(bus.ready_out), 32'd0);
    chk({tag, "_last_ch"},   32'(bus.last_ch),   32'd0);
    chk({tag, "_last"},      32'(bus.last),      32'd0);
    chk({tag, "_data_out"},  32'(bus.data_out),  32'd0);
    chk({tag, "_ch_idx"},    32'(bus.ch_idx),    32'd0);
    chk({tag, "_pix_idx"},   32'(bus.pix_idx),   32'd0);
  endtask

  initial begin
    tbl[0]  = '{8'h01, 0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h02, 0, 2'd1, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{8'h03, 5, 2'd2, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{8'h04, 0, 2'd3, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{8'h05, 0, 2'd0, 2'd1, 1'b0, 1'b0};
    tbl[5]  = '{8'h06, 0, 2'd1, 2'd1, 1'b0, 1'b0};
    tbl[6]  = '{8'h07, 0, 2'd2, 2'd1, 1'b0, 1'b0};
    tbl[7]  = '{8'h08, 0, 2'd3, 2'd1, 1'b1, 1'b0};
    tbl[8]  = '{8'h09, 0, 2'd0, 2'd2, 1'b0, 1'b0};
    tbl[9]  = '{8'h0A, 0, 2'd1, 2'd2, 1'b0, 1'b0};
    tbl[10] = '{8'h0B, 0, 2'd2, 2'd2, 1'b0, 1'b0};
    tbl[11] = '{8'h0C, 0, 2'd3, 2'd2, 1'b1, 1'b1};

    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    bus.ready_in = 1'b1;
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    model_reset();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Full frame from the beat table, with a 5-cycle downstream stall after 0x03.
    acc_count = 0;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    chk("run_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 12; i++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = tbl[i].din;
      wait_accept();
      chk("beat_valid",   32'(bus.valid_out), 32'd1);
      chk("beat_data",    32'(bus.data_out),  32'(tbl[i].din));
      chk("beat_ch",      32'(bus.ch_idx),    32'(tbl[i].ch));
      chk("beat_pix",     32'(bus.pix_idx),   32'(tbl[i].pix));
      chk("beat_last_ch", 32'(bus.last_ch),   32'(tbl[i].lch));
      chk("beat_last",    32'(bus.last),      32'(tbl[i].lst));
      for (int s = 0; s < tbl[i].stall; s++) begin
        bus.ready_in = 1'b0;
        if (i < 11) bus.data_in = tbl[i+1].din;
        cycle();
        chk("stall_data",      32'(bus.data_out),  32'(tbl[i].din));
        chk("stall_ch",        32'(bus.ch_idx),    32'(tbl[i].ch));
        chk("stall_valid",     32'(bus.valid_out), 32'd1);
        chk("stall_ready_out", 32'(bus.ready_out), 32'd0);
        chk("stall_no_accept", 32'(last_acc),      32'd0);
      end
      bus.ready_in = 1'b1;
    end
    bus.valid_in = 1'b1;
    bus.data_in  = 8'h0D;
    chk("drain_ready_out", 32'(bus.ready_out), 32'd0);
    chk("drain_busy",      32'(bus.busy),      32'd1);
    cycle();
    chk("done_pulse", 32'(bus.done), 32'd1);
    cycle();
    chk("idle_done",      32'(bus.done),      32'd0);
    chk("idle_busy",      32'(bus.busy),      32'd0);
    chk("idle_ready_out", 32'(bus.ready_out), 32'd0);
    repeat (4) cycle();
    chk("frame_beats", 32'(acc_count), 32'(N_BEATS));
    bus.valid_in = 1'b0;

    // Abort after six beats, then restart from channel 0 / pixel 0.
    bus.start = 1'b1;
    cycle();
    bus.start    = 1'b0;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.data_in = 8'(8'h10 + i);
      wait_accept();
    end
    bus.abort = 1'b1;
    cycle();
    bus.abort    = 1'b0;
    bus.valid_in = 1'b0;
    chk("abort_valid_out", 32'(bus.valid_out), 32'd0);
    chk("abort_busy",      32'(bus.busy),      32'd0);
    chk("abort_done",      32'(bus.done),      32'd0);
    repeat (3) cycle();
    bus.start = 1'b1;
    cycle();
    bus.start    = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = 8'h55;
    wait_accept();
    chk("restart_data", 32'(bus.data_out), 32'h55);
    chk("restart_ch",   32'(bus.ch_idx),   32'd0);
    chk("restart_pix",  32'(bus.pix_idx),  32'd0);

    // Start held high mid-frame must not restart the counters.
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = 8'(8'h60 + i);
      wait_accept();
    end
    chk("hold_start_ch",   32'(bus.ch_idx),   32'd3);
    chk("hold_start_pix",  32'(bus.pix_idx),  32'd0);
    chk("hold_start_data", 32'(bus.data_out), 32'h62);
    bus.start    = 1'b0;
    bus.valid_in = 1'b0;
    bus.abort    = 1'b1;
    cycle();
    chk("abort2_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    cycle();
    chk("start_abort_idle", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cycle();
    chk("start_abort_still_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of a frame, between clock edges.
    bus.start = 1'b1;
    cycle();
    bus.start    = 1'b0;
    bus.valid_in = 1'b1;
    repeat (5) begin
      bus.data_in = 8'($urandom);
      wait_accept();
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_reset_idle",      32'(bus.busy),      32'd0);
    chk("post_reset_ready_out", 32'(bus.ready_out), 32'd0);
    bus.valid_in = 1'b0;

    // Randomized traffic, backpressure, starts and rare aborts.
    frames = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.abort    = ($urandom_range(0, 199) == 0);
      bus.valid_in = ($urandom_range(0, 3) != 0);
      bus.ready_in = ($urandom_range(0, 3) != 0);
      bus.data_in  = 8'($urandom);
      cycle();
    end
    chk("random_frames_completed", 32'(frames >= 5), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv11_in_seq.md
CONV11_IN_SEQ -- requirements
Module: conv11_in_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the pixel/channel data width in bits.
REQ-002 The block SHALL have parameter CH_NUM, default 16, meaning input channels per pixel (>=2).
REQ-003 The block SHALL have parameter PIX_NUM, default 196, meaning pixels per frame (>=2).
REQ-004 The block SHALL define localparams CH_W=$clog2(CH_NUM) and PIX_W=$clog2(PIX_NUM).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: the frame start request, sampled in IDLE only.
REQ-008 The block SHALL have port abort, input, 1 bit: the synchronous frame abort.
REQ-009 The block SHALL have port valid_in, input, 1 bit: upstream data valid.
REQ-010 The block SHALL have port data_in, input, DATA_W bits: upstream data.
REQ-011 The block SHALL have port ready_out, output, 1 bit: the block accepts data_in this cycle.
REQ-012 The block SHALL have port valid_out, output, 1 bit: data_out holds a beat.
REQ-013 The block SHALL have port ready_in, input, 1 bit: downstream accepts data_out.
REQ-014 The block SHALL have port data_out, output, DATA_W bits: registered beat.
REQ-015 The block SHALL have port ch_idx, output, CH_W bits: the channel index of the beat.
REQ-016 The block SHALL have port pix_idx, output, PIX_W bits: the pixel index of the beat.
REQ-017 The block SHALL have port last_ch, output, 1 bit: the beat is channel CH_NUM-1 of its pixel.
REQ-018 The block SHALL have port last, output, 1 bit: the beat is the final beat of the frame.
REQ-019 The block SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-020 The block SHALL have port done, output, 1 bit: the one-cycle frame complete pulse.

Function
REQ-021 The block SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-022 In IDLE, start=1 SHALL clear the channel and pixel counters and move the block to RUN next cycle; start SHALL be ignored in other states.
REQ-023 ready_out SHALL be (state==RUN) && (!valid_out || ready_in), i.e. combinational pass-through of backpressure.
REQ-024 An accept (valid_in && ready_out) SHALL load data_out, ch_idx, pix_idx, last_ch and last and set valid_out on the next edge; latency is 1 cycle.
REQ-025 On accept, the channel counter SHALL increment; at CH_NUM-1 it SHALL wrap to 0 and the pixel counter SHALL increment.
REQ-026 An accept with channel=CH_NUM-1 and pixel=PIX_NUM-1 SHALL set last=1 on that beat and move the block to DRAIN.
REQ-027 While valid_out && !ready_in, data_out, ch_idx, pix_idx, last_ch, last and valid_out SHALL hold stable.
REQ-028 valid_out SHALL clear on an edge where valid_out && ready_in and no new accept occurs.
REQ-029 In DRAIN, ready_out SHALL be 0, and the block SHALL move to DONE on the edge where the last beat is consumed (valid_out && ready_in).
REQ-030 DONE SHALL last exactly one cycle with done=1 and then return to IDLE; done SHALL be 0 in all other states.
REQ-031 Exactly CH_NUM*PIX_NUM beats SHALL be accepted per frame, with no extra accept in DRAIN, DONE or IDLE.
REQ-032 abort=1 in any state SHALL, at the next edge, force IDLE, clear valid_out and the counters, and suppress done; abort SHALL take priority over start and over accept.
REQ-033 busy SHALL be 1 in RUN, DRAIN and DONE.

Reset
REQ-034 When rst_n is low, the block SHALL asynchronously set state=IDLE; valid_out, done, last_ch and last to 0; data_out, ch_idx, pix_idx and the counters to 0.
REQ-035 On rst_n assertion mid-frame, the block SHALL discard the frame with no done pulse; after release, the block SHALL require a new start.

Verification (CH_NUM=4, PIX_NUM=3, DATA_W=8)
REQ-036 The bench SHALL cover this case: start; 12 beats 0x01..0x0C with ready_in=1 held -> each valid_out one cycle after accept; ch_idx 0,1,2,3 repeating; pix_idx 0,0,0,0,1...,2; last_ch on beats 4,8,12; last on 0x0C only; done pulses once, 2 cycles after the last accept.
REQ-037 The bench SHALL cover this case: ready_in=0 for 5 cycles after beat 0x03 -> data_out=0x03/ch_idx=2 held stable, ready_out=0, no accept, no data loss on resume.
REQ-038 The bench SHALL cover this case: valid_in=1 continues after beat 12 -> ready_out=0 in DRAIN/DONE/IDLE, and a 13th beat is never accepted.
REQ-039 The bench SHALL cover this case: abort asserted after beat 6 -> IDLE next edge, valid_out=0, busy=0, no done; new start restarts at ch_idx=0, pix_idx=0.
REQ-040 The bench SHALL cover this case: start held high in RUN, and start together with abort in IDLE -> no restart and state stays IDLE respectively.
REQ-041 The bench SHALL cover this case: rst_n low mid-frame, asynchronous to clk -> outputs are reset values immediately, done never pulses, and the next frame is correct.
